// File: rtl/rob_pkg.sv
// Shared types and defaults for the reorder-buffer retirement controller.
//   rob_state_e : controller state (RUN, FLUSH)
//   commit_t    : architectural register-file write bundle {en, rd, data}
//   DEF_ROB_ENTRY_NUM / DEF_ROB_ENTRY_WIDTH : default ROB geometry
package rob_pkg;

  localparam int DEF_ROB_ENTRY_NUM   = 256;
  localparam int DEF_ROB_ENTRY_WIDTH = 8;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rob_state_e;

  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } commit_t;

endpackage

// File: rtl/rob_ptr_ctr.sv
// Head/tail pointers and occupancy count of the reorder buffer.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   inc_head        : retire the head entry this cycle
//   inc_tail        : allocate at the tail this cycle
//   clear           : squash everything (pointers and count to 0); wins over inc_*
//   head, tail      : entry indices, wrap modulo N (N must be a power of two)
//   count           : occupancy, 0..N
//   full, empty     : count == N, count == 0
module rob_ptr_ctr #(
  parameter int N = 256,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_head,
  input  logic         inc_tail,
  input  logic         clear,
  output logic [W-1:0] head,
  output logic [W-1:0] tail,
  output logic [W:0]   count,
  output logic         full,
  output logic         empty
);

  localparam logic [W:0]   FULL_CNT = (W+1)'(N);
  localparam logic [W:0]   CNT_ONE  = (W+1)'(1);
  localparam logic [W-1:0] PTR_ONE  = W'(1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (inc_head) head <= head + PTR_ONE;
      if (inc_tail) tail <= tail + PTR_ONE;
      // simultaneous alloc and retire leave the occupancy unchanged
      case ({inc_tail, inc_head})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/rob_retire_ctrl.sv
// In-order retirement / allocation controller for the reorder buffer.
// Grants one allocation per cycle to decode, retires the ready head entry
// into the architectural register file, and runs a one-cycle full flush with
// fetch redirect when a mispredicted branch retires.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   alloc_req / alloc_grant      : decode allocation handshake (grant is combinational)
//   alloc_idx                    : granted entry index (the tail)
//   full, empty, count           : occupancy status
//   head_idx                     : oldest entry, read combinationally by the ROB array
//   head_ready/rd/data/mispred/target : fields of the head entry
//   commit_en/rd/data            : registered register-file write port
//   flush, redirect_pc, rob_clear: registered one-cycle squash pulse and fetch target
// Optional build macro ROB_PERF_CNT_EN adds retired_cnt and full_stall_cnt.
//
// state | meaning
// RUN   | normal allocate / retire
// FLUSH | one cycle: flush + rob_clear high, no grant or retire, pointers cleared
module rob_retire_ctrl
  import rob_pkg::*;
#(
  parameter int ROB_ENTRY_NUM   = DEF_ROB_ENTRY_NUM,
  parameter int ROB_ENTRY_WIDTH = DEF_ROB_ENTRY_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_req,
  output logic                       alloc_grant,
  output logic [ROB_ENTRY_WIDTH-1:0] alloc_idx,
  output logic                       full,
  output logic                       empty,
  output logic [ROB_ENTRY_WIDTH:0]   count,
  output logic [ROB_ENTRY_WIDTH-1:0] head_idx,
  input  logic                       head_ready,
  input  logic [4:0]                 head_rd,
  input  logic [31:0]                head_data,
  input  logic                       head_mispred,
  input  logic [31:0]                head_target,
  output logic                       commit_en,
  output logic [4:0]                 commit_rd,
  output logic [31:0]                commit_data,
  output logic                       flush,
  output logic [31:0]                redirect_pc,
`ifdef ROB_PERF_CNT_EN
  output logic [31:0]                retired_cnt,
  output logic [31:0]                full_stall_cnt,
`endif
  output logic                       rob_clear
);

  rob_state_e  state_q, state_d;
  commit_t     commit_q;
  logic        flush_q;
  logic [31:0] redirect_q;
  logic        retire;
  logic        mispred_retire;

  assign retire         = (state_q == RUN) && !empty && head_ready;
  assign mispred_retire = retire && head_mispred;
  // no grant alongside a mispredict: the new entry would be squashed anyway
  assign alloc_grant    = alloc_req && !full && (state_q == RUN) && !mispred_retire;

  rob_ptr_ctr #(
    .N (ROB_ENTRY_NUM),
    .W (ROB_ENTRY_WIDTH)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc_head (retire),
    .inc_tail (alloc_grant),
    .clear    (state_q == FLUSH),
    .head     (head_idx),
    .tail     (alloc_idx),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mispred_retire) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // The mispredicted branch itself still commits (JAL/JALR may write rd).
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_q   <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      commit_q.en <= retire && (head_rd != 5'd0);
      if (retire) begin
        commit_q.rd   <= head_rd;
        commit_q.data <= head_data;
      end
      flush_q <= mispred_retire;
      if (mispred_retire) redirect_q <= head_target;
    end
  end

  assign commit_en   = commit_q.en;
  assign commit_rd   = commit_q.rd;
  assign commit_data = commit_q.data;
  assign flush       = flush_q;
  assign rob_clear   = flush_q;
  assign redirect_pc = redirect_q;

`ifdef ROB_PERF_CNT_EN
  // flush does not clear these; only reset does
  logic [31:0] retired_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire)            retired_q <= retired_q + 32'd1;
      if (alloc_req && full) stall_q   <= stall_q + 32'd1;
    end
  end

  assign retired_cnt    = retired_q;
  assign full_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Bench for rob_retire_ctrl: stimulus pushes (cycle, signal, value)
// expectations into a scoreboard queue; a monitor on the falling edge pops
// and compares the entries due in the current cycle.
module tb_rob_retire_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_req;
  logic        alloc_grant;
  logic [7:0]  alloc_idx;
  logic        full;
  logic        empty;
  logic [8:0]  count;
  logic [7:0]  head_idx;
  logic        head_ready;
  logic [4:0]  head_rd;
  logic [31:0] head_data;
  logic        head_mispred;
  logic [31:0] head_target;
  logic        commit_en;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        rob_clear;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] full_stall_cnt;
`endif

  always #5 clk = ~clk;

  rob_retire_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_req      (alloc_req),
    .alloc_grant    (alloc_grant),
    .alloc_idx      (alloc_idx),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .head_idx       (head_idx),
    .head_ready     (head_ready),
    .head_rd        (head_rd),
    .head_data      (head_data),
    .head_mispred   (head_mispred),
    .head_target    (head_target),
    .commit_en      (commit_en),
    .commit_rd      (commit_rd),
    .commit_data    (commit_data),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
`ifdef ROB_PERF_CNT_EN
    .retired_cnt    (retired_cnt),
    .full_stall_cnt (full_stall_cnt),
`endif
    .rob_clear      (rob_clear)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] get_act(string n);
    case (n)
      "alloc_grant": return 64'(alloc_grant);
      "alloc_idx":   return 64'(alloc_idx);
      "full":        return 64'(full);
      "empty":       return 64'(empty);
      "count":       return 64'(count);
      "head_idx":    return 64'(head_idx);
      "commit_en":   return 64'(commit_en);
      "commit_rd":   return 64'(commit_rd);
      "commit_data": return 64'(commit_data);
      "flush":       return 64'(flush);
      "rob_clear":   return 64'(rob_clear);
      "redirect_pc": return 64'(redirect_pc);
`ifdef ROB_PERF_CNT_EN
      "retired_cnt":    return 64'(retired_cnt);
      "full_stall_cnt": return 64'(full_stall_cnt);
`endif
      default:       return {64{1'bx}};
    endcase
  endfunction

  function automatic void exp_at(int c, string n, logic [63:0] v);
    exp_t e;
    e.cyc  = c;
    e.name = n;
    e.val  = v;
    sb_q.push_back(e);
  endfunction

  function automatic void exp_now(string n, logic [63:0] v);
    exp_at(cyc, n, v);
  endfunction

  function automatic void exp_next(string n, logic [63:0] v);
    exp_at(cyc + 1, n, v);
  endfunction

  // monitor
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        logic [63:0] act;
        act = get_act(sb_q[i].name);
        n_vec++;
        if (act !== sb_q[i].val) begin
          n_fail++;
          $display("FAIL %s @cycle %0d: got %0h expected %0h",
                   sb_q[i].name, cyc, act, sb_q[i].val);
        end
        sb_q.delete(i);
      end else if (sb_q[i].cyc < cyc) begin
        n_vec++;
        n_fail++;
        $display("FAIL %s @cycle %0d: never sampled, expected %0h",
                 sb_q[i].name, sb_q[i].cyc, sb_q[i].val);
        sb_q.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    alloc_req    = 1'b0;
    head_ready   = 1'b0;
    head_rd      = '0;
    head_data    = '0;
    head_mispred = 1'b0;
    head_target  = '0;
    step();
    step();
    rst = 1'b0;

    // reset / idle
    exp_now("empty", 1);        exp_now("full", 0);
    exp_now("count", 0);        exp_now("alloc_idx", 0);
    exp_now("head_idx", 0);     exp_now("commit_en", 0);
    exp_now("commit_rd", 0);    exp_now("commit_data", 0);
    exp_now("flush", 0);        exp_now("rob_clear", 0);
    exp_now("redirect_pc", 0);  exp_now("alloc_grant", 0);
    step();

    // 256 back-to-back allocations, nothing ready
    for (int i = 0; i < 256; i++) begin
      alloc_req = 1'b1;
      exp_now("alloc_grant", 1);
      exp_now("alloc_idx", 64'(i));
      exp_now("count", 64'(i));
      step();
    end

    // full: 257th request refused, head retires (rd=5)
    head_ready = 1'b1;
    head_rd    = 5'd5;
    head_data  = 32'hDEADBEEF;
    exp_now("full", 1);
    exp_now("count", 256);
    exp_now("alloc_grant", 0);
    exp_now("alloc_idx", 0);
    exp_next("commit_en", 1);
    exp_next("commit_rd", 5);
    exp_next("commit_data", 64'h0DEADBEEF);
    exp_next("head_idx", 1);
    exp_next("count", 255);
    exp_next("alloc_idx", 0);
    exp_next("full", 0);
    step();

    // grant and retire together; head_rd = 0 is never written
`ifdef ROB_PERF_CNT_EN
    exp_now("retired_cnt", 1);
    exp_now("full_stall_cnt", 1);
`endif
    head_rd   = 5'd0;
    head_data = 32'h0000_1234;
    exp_now("alloc_grant", 1);
    exp_next("count", 255);
    exp_next("commit_en", 0);
    exp_next("commit_rd", 0);
    exp_next("commit_data", 64'h1234);
    exp_next("head_idx", 2);
    exp_next("alloc_idx", 1);
    step();

    // drain down to three entries
    alloc_req = 1'b0;
    for (int i = 0; i < 252; i++) begin
      head_rd   = 5'((i % 31) + 1);
      head_data = 32'h1000 + 32'(i);
      exp_next("commit_en", 1);
      exp_next("commit_rd", 64'((i % 31) + 1));
      exp_next("commit_data", 64'(32'h1000 + 32'(i)));
      exp_next("count", 64'(254 - i));
      step();
    end

    // entry A
    head_rd   = 5'd1;
    head_data = 32'hA;
    exp_now("head_idx", 254);
    exp_next("commit_en", 1);
    exp_next("commit_data", 64'hA);
    exp_next("count", 2);
    step();

    // entry B: mispredicted branch with rd=3
    alloc_req    = 1'b1;
    head_mispred = 1'b1;
    head_target  = 32'h80;
    head_rd      = 5'd3;
    head_data    = 32'hB;
    exp_now("head_idx", 255);
    exp_now("alloc_grant", 0);
    exp_next("commit_en", 1);
    exp_next("commit_rd", 3);
    exp_next("commit_data", 64'hB);
    exp_next("flush", 1);
    exp_next("rob_clear", 1);
    exp_next("redirect_pc", 64'h80);
    exp_next("alloc_grant", 0);
    exp_next("count", 1);
    exp_next("head_idx", 0);
    step();

    // FLUSH cycle: request and ready stay high, nothing happens
    head_mispred = 1'b0;
    head_rd      = 5'd7;
    head_data    = 32'h77;
    exp_next("count", 0);
    exp_next("head_idx", 0);
    exp_next("alloc_idx", 0);
    exp_next("flush", 0);
    exp_next("rob_clear", 0);
    exp_next("commit_en", 0);
    exp_next("empty", 1);
    exp_next("alloc_grant", 1);
    step();

    // allocation resumes; empty ROB ignores head_ready
    exp_next("count", 1);
    exp_next("alloc_idx", 1);
    exp_next("head_idx", 0);
    exp_next("commit_en", 0);
    step();

    // second mispredict, reset during its FLUSH cycle
    alloc_req    = 1'b0;
    head_mispred = 1'b1;
    head_target  = 32'h200;
    head_rd      = 5'd4;
    head_data    = 32'h44;
    exp_next("flush", 1);
    exp_next("redirect_pc", 64'h200);
    exp_next("commit_rd", 4);
    step();
    rst          = 1'b1;
    head_ready   = 1'b0;
    head_mispred = 1'b0;
    step();
    rst = 1'b0;
    exp_now("flush", 0);        exp_now("rob_clear", 0);
    exp_now("redirect_pc", 0);  exp_now("commit_en", 0);
    exp_now("commit_rd", 0);    exp_now("commit_data", 0);
    exp_now("count", 0);        exp_now("empty", 1);
    exp_now("full", 0);         exp_now("head_idx", 0);
    exp_now("alloc_idx", 0);
`ifdef ROB_PERF_CNT_EN
    exp_now("retired_cnt", 0);
    exp_now("full_stall_cnt", 0);
`endif
    step();

    for (int k = 0; k < 10 && sb_q.size() != 0; k++) step();
    if (sb_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
